alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised execute stage for the multi-cycle MIPS datapath.
//  Decodes OpA plus funct (Itr), then runs the selected operation.
//  ADD/SUB/OR/AND/SLT/SLL complete in one cycle; MULT/DIV run iteratively and write HI/LO.
//  The control FSM launches work with Start and waits for Done.
// PARAMETERS
//  WIDTH    32  datapath width; power of two, >= 8
//  SH_W      5  shift-amount width, = log2(WIDTH)
// PORTS
//  clk    in   1        rising-edge clock
//  rst    in   1        synchronous, active-high reset
//  Start  in   1        operation request; sampled only while Busy=0
//  OpA    in   3        ALU op class: 000 ADD, 001 SUB, 010 R-type, others illegal
//  Itr    in   6        funct field, used only when OpA=010
//  Shamt  in   SH_W     shift amount for SLL
//  A      in   WIDTH    operand rs
//  B      in   WIDTH    operand rt
//  Busy   out  1        iterative MULT/DIV in progress
//  Done   out  1        one-cycle pulse: Res/Zero/Ill (and Hi/Lo for MULT/DIV) valid
//  Res    out  WIDTH    registered result; equals Lo after MULT/DIV
//  Zero   out  1        Res == 0 (registered with Res)
//  Hi     out  WIDTH    HI register: product high half / remainder
//  Lo     out  WIDTH    LO register: product low half / quotient
//  Ill    out  1        illegal OpA/funct; qualified by Done
//  DivZ   out  1        last DIV had B==0; qualified by Done
// BEHAVIOUR
//  Reset: all outputs 0, FSM -> IDLE. Reset mid-op aborts the op; no Done, Hi/Lo cleared.
//  FSM states: IDLE, MUL, DIV, FIX (FIX exists only with the macro).
//  Funct decode (OpA=010):
//    100000 ADD, 100010 SUB, 011000 MULT, 011010 DIV, 100101 OR,
//    100100 AND, 101010 SLT, 000000 SLL (B << Shamt; Shamt=0 is NOP).
//  Arithmetic:
//    ADD/SUB wrap modulo 2^WIDTH.
//    SLT is a signed compare; Res = {WIDTH-1 zeros, A<B}.
//  Single-cycle ops (Start at edge k, IDLE):
//    Res/Zero loaded at edge k; Done=1 during cycle k+1; Busy stays 0; Hi/Lo unchanged.
//  Illegal op: Done=1 and Ill=1 next cycle; Res, Hi and Lo unchanged.
//  MULT: shift-add over WIDTH iterations.
//    Busy=1 cycles k+1..k+WIDTH. Hi:Lo = 2*WIDTH-bit product.
//    Done=1 and Busy=0 in cycle k+WIDTH+1.
//  DIV: restoring division over WIDTH iterations; same timing as MULT. Lo=quotient, Hi=remainder.
//    B==0: no iteration. Lo=all ones, Hi=A, DivZ=1, Done next cycle (single-cycle latency).
//  Start while Busy=1 is ignored; no queueing.
//  Start in the same cycle as Done is accepted (back-to-back).
//  Operands and Shamt are captured at Start. Later changes to A/B/Itr do not affect the op in flight.
//  Ill/DivZ hold their last value between Done pulses.
// CONFIGURATION
//  ALU_SIGNED_MD_EN defined:
//    MULT/DIV are signed. Operands are converted to magnitudes at Start; the result sign is fixed in state FIX.
//    Adds 1 cycle: Done in cycle k+WIDTH+2; Busy high through k+WIDTH+1.
//    Remainder takes the sign of A. Quotient truncates toward zero.
//    Most-negative / -1: Lo=most-negative, Hi=0.
//  Not defined: MULT/DIV are unsigned. No FIX state; timing as in BEHAVIOUR.
// TESTING (WIDTH=32)
//  OpA=010, Itr=100000, A=7FFFFFFF, B=1 -> next cycle Done=1, Res=80000000, Zero=0.
//  OpA=010, Itr=101010, A=FFFFFFFF, B=1 -> Res=1. Then Itr=000000, Shamt=4, B=0000000F -> Res=000000F0.
//  MULT A=FFFFFFFF, B=2, unsigned -> Busy 32 cycles, Done in cycle 33: Hi=00000001, Lo=FFFFFFFE.
//    With ALU_SIGNED_MD_EN -> Done in cycle 34: Hi=FFFFFFFF, Lo=FFFFFFFE.
//  DIV A=100, B=7 -> Lo=14, Hi=2. DIV B=0 -> Done next cycle, DivZ=1, Lo=FFFFFFFF, Hi=A.
//  Start during Busy with a new op -> ignored; original result intact. Start in the Done cycle -> new op runs.
//  rst at cycle 10 of a MULT -> Busy=0, Hi=Lo=0, no Done. Next Start runs normally.
//  OpA=101 or Itr=111111 -> Done=1, Ill=1, Res unchanged.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Multi-cycle MIPS execute stage: single-cycle ALU ops plus iterative MULT/DIV into HI/LO.
// Define ALU_SIGNED_MD_EN for signed MULT/DIV (magnitude iteration plus a sign-fix state).
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SH_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [2:0]       OpA,
    input  logic [5:0]       Itr,
    input  logic [SH_W-1:0]  Shamt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Res,
    output logic             Zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Ill,
    output logic             DivZ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
`ifdef ALU_SIGNED_MD_EN
        , S_FIX
`endif
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLT, OP_SLL, OP_MULT, OP_DIV, OP_ILL
    } op_t;

    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(WIDTH - 1);

    state_t           state, state_next;
    op_t              op;
    logic             accept;
    logic             last_iter;
    logic             finish;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [SH_W-1:0]  count;
    logic             is_div;
    logic [WIDTH:0]   mul_sum, div_part, div_diff;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] fin_hi, fin_lo;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign accept    = Start && (state == S_IDLE);
    assign last_iter = (count == CNT_LAST);
    assign Busy      = (state != S_IDLE);

    always_comb begin
        op = OP_ILL;
        case (OpA)
            3'b000: op = OP_ADD;
            3'b001: op = OP_SUB;
            3'b010: begin
                case (Itr)
                    6'b100000: op = OP_ADD;
                    6'b100010: op = OP_SUB;
                    6'b011000: op = OP_MULT;
                    6'b011010: op = OP_DIV;
                    6'b100101: op = OP_OR;
                    6'b100100: op = OP_AND;
                    6'b101010: op = OP_SLT;
                    6'b000000: op = OP_SLL;
                    default:   op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_OR:   alu_res = A | B;
            OP_AND:  alu_res = A & B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL:  alu_res = B << Shamt;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_SIGNED_MD_EN
    logic                 neg_q, neg_r;
    logic [2*WIDTH-1:0]   prod_mag, prod_fix;

    assign mag_a = A[WIDTH-1] ? -A : A;
    assign mag_b = B[WIDTH-1] ? -B : B;

    // Iteration runs on magnitudes; signs are re-applied from acc in S_FIX.
    always_comb begin
        prod_mag = {acc_hi, acc_lo};
        prod_fix = neg_q ? -prod_mag : prod_mag;
        if (is_div) begin
            fin_hi = neg_r ? -acc_hi : acc_hi;
            fin_lo = neg_q ? -acc_lo : acc_lo;
        end else begin
            {fin_hi, fin_lo} = prod_fix;
        end
    end
`else
    assign mag_a  = A;
    assign mag_b  = B;
    assign fin_hi = step_hi;
    assign fin_lo = step_lo;
`endif

    // acc_hi:acc_lo is product shift register for MULT, remainder:quotient for DIV.
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
        div_part = {acc_hi, acc_lo[WIDTH-1]};
        div_diff = div_part - {1'b0, opnd};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_part[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (op == OP_MULT)                    state_next = S_MUL;
                    else if (op == OP_DIV && B != '0)     state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) begin
`ifdef ALU_SIGNED_MD_EN
                    state_next = S_FIX;
`else
                    state_next = S_IDLE;
                    finish     = 1'b1;
`endif
                end
            end
`ifdef ALU_SIGNED_MD_EN
            S_FIX: begin
                state_next = S_IDLE;
                finish     = 1'b1;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Done   <= 1'b0;
            Res    <= '0;
            Zero   <= 1'b0;
            Hi     <= '0;
            Lo     <= '0;
            Ill    <= 1'b0;
            DivZ   <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            count  <= '0;
            is_div <= 1'b0;
`ifdef ALU_SIGNED_MD_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            if (accept) begin
                case (op)
                    OP_ILL: begin
                        Done <= 1'b1;
                        Ill  <= 1'b1;
                    end
                    OP_MULT, OP_DIV: begin
                        if (op == OP_DIV && B == '0) begin
                            Lo   <= '1;
                            Hi   <= A;
                            Res  <= '1;
                            Zero <= 1'b0;
                            DivZ <= 1'b1;
                            Ill  <= 1'b0;
                            Done <= 1'b1;
                        end else begin
                            acc_hi <= '0;
                            acc_lo <= (op == OP_DIV) ? mag_a : mag_b;
                            opnd   <= (op == OP_DIV) ? mag_b : mag_a;
                            count  <= '0;
                            is_div <= (op == OP_DIV);
`ifdef ALU_SIGNED_MD_EN
                            neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                            neg_r  <= A[WIDTH-1];
`endif
                        end
                    end
                    default: begin
                        Res  <= alu_res;
                        Zero <= (alu_res == '0);
                        Ill  <= 1'b0;
                        Done <= 1'b1;
                    end
                endcase
            end
            if (state == S_MUL || state == S_DIV) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count + SH_W'(1);
            end
            if (finish) begin
                Hi   <= fin_hi;
                Lo   <= fin_lo;
                Res  <= fin_lo;
                Zero <= (fin_lo == '0);
                Ill  <= 1'b0;
                if (is_div) DivZ <= 1'b0;
                Done <= 1'b1;
            end
        end
    end

endmodule
